// File: rtl/ece453_avalon_master_pkg.sv
// Shared types and constants for the ece453 Avalon-MM master and its helpers.
package ece453_avalon_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_WAIT_RD = 2'd2,
    ST_RSP     = 2'd3
  } state_t;

  localparam int WORD_BYTES      = 4;
  localparam int DEFAULT_TIMEOUT = 1024;

  // Counter width able to hold the value 'limit' itself; at least one bit.
  function automatic int cnt_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/ece453_timeout_counter.sv
// Saturating cycle counter with clear/enable; expired goes high once LIMIT cycles
// have been counted since the last clear. LIMIT=0 never expires.
module ece453_timeout_counter
  import ece453_avalon_master_pkg::*;
#(
  parameter int LIMIT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            W       = cnt_width(LIMIT);
  localparam logic [W-1:0]  LIMIT_V = W'(LIMIT);
  localparam bit            ENABLED = (LIMIT != 0);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  assign expired = ENABLED && (count_q == LIMIT_V);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !expired) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ece453_avalon_master.sv
// Avalon-MM master: turns one command into N sequential word accesses, one at a
// time, and returns one response per word through a valid/ready response port.
module ece453_avalon_master
  import ece453_avalon_master_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_byteenable,
  output logic [ADDR_W-1:0] master_address,
  output logic              master_read,
  output logic              master_write,
  output logic [31:0]       master_writedata,
  output logic [3:0]        master_byteenable,
  input  logic              master_waitrequest,
  input  logic [31:0]       master_readdata,
  input  logic              master_readdatavalid,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_data,
  output logic              rsp_error,
  output logic              rsp_last,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // Handshakes: cmd and rsp transfer on a cycle where valid && ready are both
  // high; valid and its payload never change while waiting for ready. The bus
  // request is held with stable address/data until waitrequest is low.

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(WORD_BYTES - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(WORD_BYTES);
  localparam logic [LEN_W-1:0]  ONE_WORD   = LEN_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic              is_write_q, is_write_d;
  logic [LEN_W-1:0]  words_left_q, words_left_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_error_q, rsp_error_d;

  logic to_clear;
  logic to_enable;
  logic to_expired;
  logic last_word;

  ece453_timeout_counter #(
    .LIMIT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (to_clear),
    .enable  (to_enable),
    .expired (to_expired)
  );

  assign last_word = (words_left_q == ONE_WORD) || rsp_error_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    be_d         = be_q;
    is_write_d   = is_write_q;
    words_left_d = words_left_q;
    rsp_data_d   = rsp_data_q;
    rsp_error_d  = rsp_error_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          is_write_d   = cmd_write;
          addr_d       = cmd_address & ALIGN_MASK;
          wdata_d      = cmd_wdata;
          be_d         = cmd_byteenable;
          words_left_d = (cmd_len == '0) ? ONE_WORD : cmd_len;
          rsp_data_d   = '0;
          rsp_error_d  = 1'b0;
          state_d      = ST_REQ;
        end
      end

      ST_REQ: begin
        if (to_expired) begin
          rsp_data_d  = '0;
          rsp_error_d = 1'b1;
          state_d     = ST_RSP;
        end else if (!master_waitrequest) begin
          if (is_write_q) begin
            rsp_data_d = '0;
            state_d    = ST_RSP;
          end else if (master_readdatavalid) begin
            // Zero-latency slave: data comes back with the accept.
            rsp_data_d = master_readdata;
            state_d    = ST_RSP;
          end else begin
            state_d = ST_WAIT_RD;
          end
        end
      end

      ST_WAIT_RD: begin
        if (to_expired) begin
          rsp_data_d  = '0;
          rsp_error_d = 1'b1;
          state_d     = ST_RSP;
        end else if (master_readdatavalid) begin
          rsp_data_d = master_readdata;
          state_d    = ST_RSP;
        end
      end

      ST_RSP: begin
        if (rsp_ready) begin
          words_left_d = words_left_q - 1'b1;
          if (last_word) begin
            state_d = ST_IDLE;
          end else begin
            addr_d  = addr_q + ADDR_STEP;
            state_d = ST_REQ;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // The timeout window restarts every time REQ or WAIT_RD is entered.
  assign to_clear  = (state_d != state_q);
  assign to_enable = (state_q == ST_REQ) || (state_q == ST_WAIT_RD);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      is_write_q   <= 1'b0;
      words_left_q <= '0;
      rsp_data_q   <= '0;
      rsp_error_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      be_q         <= be_d;
      is_write_q   <= is_write_d;
      words_left_q <= words_left_d;
      rsp_data_q   <= rsp_data_d;
      rsp_error_q  <= rsp_error_d;
    end
  end

  assign cmd_ready         = (state_q == ST_IDLE);
  assign busy              = (state_q != ST_IDLE);
  assign dbg_state         = state_q;
  assign master_address    = addr_q;
  assign master_writedata  = wdata_q;
  assign master_byteenable = be_q;
  assign master_read       = (state_q == ST_REQ) && !is_write_q && !to_expired;
  assign master_write      = (state_q == ST_REQ) &&  is_write_q && !to_expired;
  assign rsp_valid         = (state_q == ST_RSP);
  assign rsp_data          = rsp_data_q;
  assign rsp_error         = rsp_valid && rsp_error_q;
  assign rsp_last          = rsp_valid && last_word;

endmodule
